instruction_fetch_queue: RTL and testbench
==========================================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 The block SHALL have these parameters: N, 64, address width (N >= 32); RESET_ADDR, 0, PC loaded on reset; DEPTH, 2, queue entries (power of two, >= 2).
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: redirect_en  input  1  branch/jump/trap redirect strobe.
REQ-005 Port: redirect_addr  input  N  new fetch address.
REQ-006 Port: mem_rd_en  output  1  instruction memory read request.
REQ-007 Port: mem_addr  output  N  request address.
REQ-008 Port: mem_ack  input  1  read completion, one cycle per request.
REQ-009 Port: mem_rd_dat  input  32  read data, valid with mem_ack.
REQ-010 Port: instruction  output  32  head instruction word, consumed by the immediate extender and decoder.
REQ-011 Port: instruction_pc  output  N  address of the head instruction.
REQ-012 Port: instruction_valid  output  1  head entry valid.
REQ-013 Port: instruction_ready  input  1  decode stage accepts the head.

Function
REQ-014 FSM states SHALL be IDLE (no request), REQ (request outstanding) and FLUSH (outstanding request whose response is discarded).
REQ-015 IDLE->REQ SHALL occur when occupancy < DEPTH and no redirect occurs; mem_rd_en = 1 and mem_addr = pc in REQ and FLUSH.
REQ-016 At most one request SHALL be outstanding; mem_addr and mem_rd_en SHALL stay stable until mem_ack.
REQ-017 In REQ, on mem_ack without redirect: push {mem_rd_dat, pc}, pc <= pc + 4 (mod 2^N); next state REQ if occupancy after the push and pop < DEPTH, else IDLE.
REQ-018 No request SHALL be issued while occupancy + outstanding requests = DEPTH, so a push never targets a full queue.
REQ-019 Pop SHALL occur when instruction_valid and instruction_ready are both high; a simultaneous push and pop leaves occupancy unchanged.
REQ-020 instruction_valid = (occupancy != 0); instruction and instruction_pc SHALL show the oldest entry; read and write pointers wrap modulo DEPTH.
REQ-021 On redirect_en the block SHALL clear the queue, ignore any pop in that cycle, and set pc <= {redirect_addr[N-1:2], 2'b00}.
REQ-022 If a redirect occurs in REQ without mem_ack, the next state SHALL be FLUSH; in FLUSH, mem_ack discards the data and moves to REQ at the new pc.
REQ-023 If a redirect occurs in the same cycle as mem_ack, the data SHALL be discarded and the next state SHALL be REQ at the redirect address.
REQ-024 A redirect in FLUSH SHALL update pc and stay in FLUSH; a redirect in IDLE SHALL move to REQ.
REQ-025 The fetch-to-head latency SHALL be 1 cycle after mem_ack; sustained throughput is 1 instruction per memory ack.

Reset
REQ-026 While reset = 0 the block SHALL force pc = RESET_ADDR, occupancy 0, pointers 0, state IDLE, and mem_rd_en, instruction_valid, instruction and instruction_pc to 0.
REQ-027 The first request SHALL be issued to RESET_ADDR in the cycle after reset deasserts.
REQ-028 Reset asserted mid-request SHALL abandon the request; a later mem_ack while in IDLE SHALL be ignored.

Configuration
REQ-029 With macro FETCH_BYPASS_EN defined: when the queue is empty and mem_ack arrives with no redirect, instruction_valid, instruction and instruction_pc SHALL present mem_rd_dat and pc combinationally in the same cycle.
REQ-030 Under FETCH_BYPASS_EN, if instruction_ready is also high in that cycle, the word SHALL NOT be written to the queue.
REQ-031 Without FETCH_BYPASS_EN, all outputs SHALL be registered and REQ-025 latency applies.

Verification
REQ-032 Reset release, RESET_ADDR=0x1000, mem_ack one cycle after each request, ready=1 -> mem_addr sequence 0x1000, 0x1004, 0x1008; head PCs in the same order.
REQ-033 ready=0 with DEPTH=2 -> exactly 2 acks accepted, then mem_rd_en=0; raising ready gives one pop, followed by one new request.
REQ-034 Redirect to 0x2003 while a request is pending with no ack -> FLUSH; the stale ack data is dropped; next mem_addr = 0x2000; queue is empty meanwhile.
REQ-035 Redirect in the same cycle as mem_ack -> no push; next mem_addr = redirect target; instruction_valid = 0 the next cycle.
REQ-036 pc = 2^N - 4, ack received -> next mem_addr = 0 (wrap-around).
REQ-037 FETCH_BYPASS_EN defined, queue empty, ack 0x00500093 with ready=1 -> instruction = 0x00500093 in the same cycle, occupancy stays 0.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Purpose: fetches 32-bit instruction words from instruction memory, one
// request outstanding at a time, and buffers them in a small FIFO in front of
// the decode stage. Branch/jump/trap redirects flush the FIFO and restart
// fetching at the new (word-aligned) address. A response to a request that was
// overtaken by a redirect is discarded.
//
// Parameters:
//   N          address width (>= 32)
//   RESET_ADDR fetch address loaded on reset
//   DEPTH      FIFO entries (power of two, >= 2)
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous active-low reset
//   redirect_en        redirect strobe
//   redirect_addr      new fetch address (low two bits ignored)
//   mem_rd_en          memory read request (held until mem_ack)
//   mem_addr           memory request address
//   mem_ack            read completion, one cycle per request
//   mem_rd_dat         read data, valid with mem_ack
//   instruction        head instruction word
//   instruction_pc     address of the head instruction
//   instruction_valid  head entry valid
//   instruction_ready  decode accepts the head
//
// Optional feature (macro FETCH_BYPASS_EN): when the FIFO is empty, a word
// arriving on mem_ack is presented on the head outputs in the same cycle and is
// not stored if instruction_ready is also high. Without the macro every output
// is driven from registers only.
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int unsigned    N          = 64,
  parameter logic [N-1:0]   RESET_ADDR = '0,
  parameter int unsigned    DEPTH      = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          redirect_en,
  input  logic [N-1:0]  redirect_addr,
  output logic          mem_rd_en,
  output logic [N-1:0]  mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rd_dat,
  output logic [31:0]   instruction,
  output logic [N-1:0]  instruction_pc,
  output logic          instruction_valid,
  input  logic          instruction_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]    dat_q [DEPTH];
  logic [N-1:0]   epc_q [DEPTH];

  logic           head_valid_s;
  logic           ack_ok_s;
  logic           bypass_s;
  logic           push_s;
  logic           pop_s;
  logic [CW-1:0]  count_after_s;

  // Handshake qualifiers shared by the FSM, the FIFO and the head outputs.
  always_comb begin
    head_valid_s = (count_q != {CW{1'b0}});
    // Only a response to a live (non-flushed) request carries a usable word.
    ack_ok_s     = (state_q == REQ) && mem_ack && !redirect_en;
`ifdef FETCH_BYPASS_EN
    bypass_s     = ack_ok_s && !head_valid_s;
`else
    bypass_s     = 1'b0;
`endif
    // A redirect cancels any pop in the same cycle.
    pop_s        = head_valid_s && instruction_ready && !redirect_en;
    // A bypassed word consumed directly by decode never enters the FIFO.
    push_s       = ack_ok_s && !(bypass_s && instruction_ready);
    count_after_s = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
  end

  // Next-state logic for the fetch FSM, fetch address and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    case (state_q)
      IDLE: begin
        // occupancy < DEPTH guarantees room for the response of a new request
        if (redirect_en) begin
          state_d = REQ;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect_en) begin
          // Without an ack the old request is still in flight: its data must be dropped.
          state_d = mem_ack ? REQ : FLUSH;
        end else if (mem_ack) begin
          state_d = (count_after_s < DEPTH_C) ? REQ : IDLE;
        end else begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        // The stale response retires here; a redirect without ack keeps waiting.
        if (mem_ack) begin
          state_d = REQ;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_en) begin
      pc_d = redirect_addr & ~(N'(3));
    end else if (ack_ok_s) begin
      pc_d = pc_q + N'(4);
    end else begin
      pc_d = pc_q;
    end

    if (redirect_en) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      count_d  = count_after_s;
      rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end
  end

  // FSM state, fetch address and FIFO pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_ADDR;
      count_q  <= {CW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat_q[i] <= 32'h0;
        epc_q[i] <= {N{1'b0}};
      end
    end else if (push_s) begin
      dat_q[wr_ptr_q] <= mem_rd_dat;
      epc_q[wr_ptr_q] <= pc_q;
    end
  end

  assign mem_rd_en = (state_q != IDLE);
  assign mem_addr  = pc_q;

  // Head outputs: oldest FIFO entry, or the arriving word when bypassing.
  always_comb begin
    instruction       = dat_q[rd_ptr_q];
    instruction_pc    = epc_q[rd_ptr_q];
    instruction_valid = head_valid_s;
    if (bypass_s) begin
      instruction       = mem_rd_dat;
      instruction_pc    = pc_q;
      instruction_valid = 1'b1;
    end else begin
      instruction_valid = head_valid_s;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// Self-checking bench for instruction_fetch_queue (N=64, RESET_ADDR=0x1000,
// DEPTH=2). A reference model built from a queue of {word, pc}, a fetch pc
// and "request outstanding"/"response to discard" flags predicts every output
// each cycle. Directed sequences cover in-order fetch, back-pressure, flush,
// redirect-with-ack and address wrap; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

  localparam int unsigned DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h1000;

  logic         clock = 1'b0;
  logic         reset;
  logic         redirect_en;
  logic [63:0]  redirect_addr;
  logic         mem_rd_en;
  logic [63:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rd_dat;
  logic [31:0]  instruction;
  logic [63:0]  instruction_pc;
  logic         instruction_valid;
  logic         instruction_ready;

  instruction_fetch_queue #(
    .N          (64),
    .RESET_ADDR (RESET_PC),
    .DEPTH      (DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_en       (redirect_en),
    .redirect_addr     (redirect_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rd_dat        (mem_rd_dat),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] m_dat [$];
  logic [63:0] m_pc  [$];
  logic [63:0] m_fetch_pc;
  bit          m_busy;
  bit          m_drop;

  // Observation logs (values seen on the DUT ports)
  logic [63:0] addr_log [$];
  logic [63:0] head_log [$];
  logic        obs_valid;
  logic [31:0] obs_instr;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dat.delete();
    m_pc.delete();
    m_fetch_pc = RESET_PC;
    m_busy     = 1'b0;
    m_drop     = 1'b0;
  endtask

  task automatic drive_idle();
    redirect_en       = 1'b0;
    redirect_addr     = 64'h0;
    mem_ack           = 1'b0;
    mem_rd_dat        = 32'h0;
    instruction_ready = 1'b0;
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic apply_reset(input int hold);
    reset = 1'b0;
    drive_idle();
    model_reset();
    for (int i = 0; i < hold; i++) begin
      #1;
      check_value("rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
      check_value("rst_valid", {63'h0, instruction_valid}, 64'h0);
      check_value("rst_instr", {32'h0, instruction}, 64'h0);
      check_value("rst_pc", instruction_pc, 64'h0);
      @(negedge clock);
    end
    reset = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model at the rising edge.
  task automatic cycle(input bit red, input logic [63:0] ra, input bit ack,
                       input logic [31:0] dat, input bit rdy);
    bit byp;
    bit exp_valid;
    bit pop;
    int occ;
    redirect_en       = red;
    redirect_addr     = ra;
    mem_ack           = ack;
    mem_rd_dat        = dat;
    instruction_ready = rdy;
    #1;
    obs_valid = instruction_valid;
    obs_instr = instruction;

    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (m_dat.size() == 0) && m_busy && !m_drop && ack && !red;
`endif
    exp_valid = (m_dat.size() != 0) || byp;

    check_value("mem_rd_en", {63'h0, mem_rd_en}, {63'h0, m_busy});
    if (m_busy) check_value("mem_addr", mem_addr, m_fetch_pc);
    check_value("instr_valid", {63'h0, instruction_valid}, {63'h0, exp_valid});
    if (exp_valid) begin
      check_value("instr", {32'h0, instruction}, {32'h0, (byp ? dat : m_dat[0])});
      check_value("instr_pc", instruction_pc, (byp ? m_fetch_pc : m_pc[0]));
    end
    if (mem_rd_en && ack && !red) addr_log.push_back(mem_addr);
    if (instruction_valid && rdy && !red) head_log.push_back(instruction_pc);

    @(posedge clock);
    occ = m_dat.size();
    pop = (occ != 0) && rdy && !red;
    if (red) begin
      m_dat.delete();
      m_pc.delete();
      m_fetch_pc = ra & ~64'h3;
      if (m_busy && !ack) begin
        m_drop = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_drop = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(m_dat.pop_front());
        void'(m_pc.pop_front());
      end
      if (m_busy && ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          if (!(byp && rdy)) begin
            m_dat.push_back(dat);
            m_pc.push_back(m_fetch_pc);
          end
          m_fetch_pc = m_fetch_pc + 64'h4;
          m_busy = (m_dat.size() < DEPTH);
        end
      end else if (!m_busy) begin
        m_busy = (occ < DEPTH);
      end
    end
    #1;
    drive_idle();
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra;
    bit          red_r, ack_r, rdy_r;
    reset = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clock);
    apply_reset(3);

    // In-order fetch from RESET_ADDR with an ack after every request
    addr_log.delete();
    head_log.delete();
    cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, $urandom(), 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_value("seq_n_req", 64'(addr_log.size()), 64'd3);
    check_value("seq_addr0", addr_log[0], 64'h1000);
    check_value("seq_addr1", addr_log[1], 64'h1004);
    check_value("seq_addr2", addr_log[2], 64'h1008);
    check_value("seq_n_head", 64'(head_log.size()), 64'd3);
    check_value("seq_head0", head_log[0], 64'h1000);
    check_value("seq_head1", head_log[1], 64'h1004);
    check_value("seq_head2", head_log[2], 64'h1008);

    // Back-pressure: reset mid-request, stray ack in IDLE, then ready low
    apply_reset(2);
    addr_log.delete();
    head_log.delete();
    cycle(1'b0, 64'h0, 1'b1, $urandom(), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'h0, 1'b1, $urandom(), 1'b0);
    check_value("bp_acks", 64'(addr_log.size()), 64'd2);
    check_value("bp_stall", {63'h0, mem_rd_en}, 64'h0);
    cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    check_value("bp_pops", 64'(head_log.size()), 64'd1);
    check_value("bp_pop_pc", head_log[0], 64'h1000);
    cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    check_value("bp_req", {63'h0, mem_rd_en}, 64'h1);
    check_value("bp_req_addr", mem_addr, 64'h1008);

    // Redirect with a request pending and no ack: stale data dropped
    cycle(1'b1, 64'h2003, 1'b0, 32'h0, 1'b1);
    check_value("fl_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check_value("fl_addr", mem_addr, 64'h2000);
    check_value("fl_valid", {63'h0, instruction_valid}, 64'h0);
    cycle(1'b0, 64'h0, 1'b1, 32'hDEADBEEF, 1'b1);
    check_value("fl_drop_valid", {63'h0, instruction_valid}, 64'h0);
    check_value("fl_drop_addr", mem_addr, 64'h2000);
    cycle(1'b0, 64'h0, 1'b1, 32'h00500093, 1'b0);
    check_value("fl_new_valid", {63'h0, instruction_valid}, 64'h1);
    check_value("fl_new_instr", {32'h0, instruction}, 64'h00500093);
    check_value("fl_new_pc", instruction_pc, 64'h2000);
    check_value("fl_next_addr", mem_addr, 64'h2004);

    // Redirect coinciding with mem_ack: no push, restart at target
    cycle(1'b1, 64'h3000, 1'b1, 32'h12345678, 1'b1);
    check_value("ra_valid", {63'h0, instruction_valid}, 64'h0);
    check_value("ra_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check_value("ra_addr", mem_addr, 64'h3000);

    // Fetch address wrap at the top of the address space
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, $urandom(), 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    check_value("wrap_addr", mem_addr, 64'h0);
    check_value("wrap_head_pc", instruction_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_value("wrap_head", {32'h0, instruction}, 64'hCAFEF00D);

`ifdef FETCH_BYPASS_EN
    // Same-cycle bypass into an empty FIFO, consumed immediately
    apply_reset(2);
    cycle(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 32'h00500093, 1'b1);
    check_value("byp_valid", {63'h0, obs_valid}, 64'h1);
    check_value("byp_instr", {32'h0, obs_instr}, 64'h00500093);
    check_value("byp_empty", {63'h0, instruction_valid}, 64'h0);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2400; i++) begin
      if ((i % 600) == 0) apply_reset($urandom_range(1, 3));
      red_r = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       ra = {$urandom(), $urandom()};
        1:       ra = 64'h2003;
        2:       ra = 64'hFFFF_FFFF_FFFF_FFFE;
        default: ra = 64'h1000 + 64'($urandom_range(0, 63));
      endcase
      ack_r = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      cycle(red_r, ra, ack_r, $urandom(), rdy_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
